// File: rtl/ccip_mmio_csr_bank.sv
// CCI-P MMIO CSR bank: AFU header, scratch, cycle counter, NIC control/status registers.
// Writes commit one cycle after acceptance; reads answer two cycles after the request.
module ccip_mmio_csr_bank #(
   parameter logic [63:0] AFU_ID_L        = 64'h0,
   parameter logic [63:0] AFU_ID_H        = 64'h0,
   parameter logic [63:0] DFH_VALUE       = 64'h1000_0000_0000_0001,
   parameter int          NUM_USER_REGS   = 8,
   parameter int          NUM_STATUS_REGS = 4
)(
   input  logic                           pClk,
   input  logic                           pReset_n,
   input  logic                           mmio_wr_valid,
   input  logic [15:0]                    mmio_wr_addr,
   input  logic [1:0]                     mmio_wr_len,
   input  logic [63:0]                    mmio_wr_data,
   input  logic                           mmio_rd_valid,
   input  logic [15:0]                    mmio_rd_addr,
   input  logic [1:0]                     mmio_rd_len,
   input  logic [8:0]                     mmio_rd_tid,
   output logic                           c2_rsp_valid,
   output logic [8:0]                     c2_rsp_tid,
   output logic [63:0]                    c2_rsp_data,
   output logic [64*NUM_USER_REGS-1:0]    usr_regs,
   output logic [NUM_USER_REGS-1:0]       usr_wr_pulse,
   input  logic [64*NUM_STATUS_REGS-1:0]  status_regs
);

   localparam logic [14:0] IDX_DFH     = 15'd0;
   localparam logic [14:0] IDX_ID_L    = 15'd1;
   localparam logic [14:0] IDX_ID_H    = 15'd2;
   localparam logic [14:0] IDX_SCRATCH = 15'd5;
   localparam logic [14:0] IDX_CYCLE   = 15'd6;
   localparam int          USER_BASE   = 8;
   localparam int          STATUS_BASE = USER_BASE + NUM_USER_REGS;

   function automatic logic [63:0] mergeWrite(input logic [63:0] oldVal, input logic full,
                                              input logic upper, input logic [63:0] data);
      if (full)  return data;
      if (upper) return {data[31:0], oldVal[31:0]};
      return {oldVal[63:32], data[31:0]};
   endfunction

   // Pending write, committed on the following edge
   logic        wrValidReg;
   logic [14:0] wrIdxReg;
   logic        wrUpperReg;
   logic        wrFullReg;
   logic [63:0] wrDataReg;

   logic [63:0] scratchReg, scratchNext;
   logic [63:0] cycleCntReg, cycleCntNext;
   logic [63:0] usrReg  [NUM_USER_REGS];
   logic [63:0] usrNext [NUM_USER_REGS];
   logic [NUM_USER_REGS-1:0] usrHit;

   logic        rdValidReg;
   logic [8:0]  rdTidReg;
   logic        rdHalfReg;
   logic        rdUpperReg;
   logic [63:0] rdDataReg;
   logic [63:0] rdSrc;
   logic [14:0] rdIdx;
   logic        wrAccept;

   // 64B bursts and misaligned 8B writes never reach the pending stage
   assign wrAccept = mmio_wr_valid &&
                     ((mmio_wr_len == 2'd0) || ((mmio_wr_len == 2'd1) && !mmio_wr_addr[0]));
   assign rdIdx    = mmio_rd_addr[15:1];

   assign scratchNext  = (wrValidReg && (wrIdxReg == IDX_SCRATCH))
                         ? mergeWrite(scratchReg, wrFullReg, wrUpperReg, wrDataReg) : scratchReg;
   assign cycleCntNext = (wrValidReg && (wrIdxReg == IDX_CYCLE)) ? 64'd0 : cycleCntReg + 64'd1;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_USER_REGS; gi++) begin : gUsr
         assign usrHit[gi]  = wrValidReg && (wrIdxReg == 15'(USER_BASE + gi));
         assign usrNext[gi] = usrHit[gi]
                              ? mergeWrite(usrReg[gi], wrFullReg, wrUpperReg, wrDataReg) : usrReg[gi];
         assign usr_regs[64*gi +: 64] = usrReg[gi];
      end
   endgenerate

   // Sources are the post-edge values, so a write accepted one cycle earlier is visible
   always_comb begin
      rdSrc = '0;
      case (rdIdx)
         IDX_DFH:     rdSrc = DFH_VALUE;
         IDX_ID_L:    rdSrc = AFU_ID_L;
         IDX_ID_H:    rdSrc = AFU_ID_H;
         IDX_SCRATCH: rdSrc = scratchNext;
         IDX_CYCLE:   rdSrc = cycleCntNext;
         default:     rdSrc = '0;
      endcase
      for (int i = 0; i < NUM_USER_REGS; i++) begin
         if (rdIdx == 15'(USER_BASE + i)) rdSrc = usrNext[i];
      end
      for (int j = 0; j < NUM_STATUS_REGS; j++) begin
         if (rdIdx == 15'(STATUS_BASE + j)) rdSrc = status_regs[64*j +: 64];
      end
   end

   always_ff @(posedge pClk) begin
      if (!pReset_n) begin
         wrValidReg   <= 1'b0;
         wrIdxReg     <= '0;
         wrUpperReg   <= 1'b0;
         wrFullReg    <= 1'b0;
         wrDataReg    <= '0;
         scratchReg   <= '0;
         cycleCntReg  <= '0;
         for (int i = 0; i < NUM_USER_REGS; i++) usrReg[i] <= '0;
         usr_wr_pulse <= '0;
         rdValidReg   <= 1'b0;
         rdTidReg     <= '0;
         rdHalfReg    <= 1'b0;
         rdUpperReg   <= 1'b0;
         rdDataReg    <= '0;
         c2_rsp_valid <= 1'b0;
         c2_rsp_tid   <= '0;
         c2_rsp_data  <= '0;
      end else begin
         wrValidReg   <= wrAccept;
         wrIdxReg     <= mmio_wr_addr[15:1];
         wrUpperReg   <= mmio_wr_addr[0];
         wrFullReg    <= (mmio_wr_len == 2'd1);
         wrDataReg    <= mmio_wr_data;
         scratchReg   <= scratchNext;
         cycleCntReg  <= cycleCntNext;
         for (int i = 0; i < NUM_USER_REGS; i++) usrReg[i] <= usrNext[i];
         usr_wr_pulse <= usrHit;
         rdValidReg   <= mmio_rd_valid;
         rdTidReg     <= mmio_rd_tid;
         rdHalfReg    <= (mmio_rd_len == 2'd0);
         rdUpperReg   <= mmio_rd_addr[0];
         rdDataReg    <= rdSrc;
         c2_rsp_valid <= rdValidReg;
         c2_rsp_tid   <= rdTidReg;
         c2_rsp_data  <= rdHalfReg ? {2{rdUpperReg ? rdDataReg[63:32] : rdDataReg[31:0]}}
                                   : rdDataReg;
      end
   end

endmodule

// File: tb/tb_ccip_mmio_csr_bank.sv
// Scoreboard bench for ccip_mmio_csr_bank: a register-map model predicts every read
// response; a monitor pops predictions as responses appear on C2.
module tb_ccip_mmio_csr_bank;

   localparam int          NU   = 8;
   localparam int          NS   = 4;
   localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] DFH  = 64'h1000_0000_0000_0001;

   logic              pClk = 1'b0;
   logic              pReset_n = 1'b0;
   logic              mmio_wr_valid = 1'b0;
   logic [15:0]       mmio_wr_addr = '0;
   logic [1:0]        mmio_wr_len = '0;
   logic [63:0]       mmio_wr_data = '0;
   logic              mmio_rd_valid = 1'b0;
   logic [15:0]       mmio_rd_addr = '0;
   logic [1:0]        mmio_rd_len = '0;
   logic [8:0]        mmio_rd_tid = '0;
   logic              c2_rsp_valid;
   logic [8:0]        c2_rsp_tid;
   logic [63:0]       c2_rsp_data;
   logic [64*NU-1:0]  usr_regs;
   logic [NU-1:0]     usr_wr_pulse;
   logic [64*NS-1:0]  status_regs = '0;

   always #5 pClk = ~pClk;

   ccip_mmio_csr_bank #(
      .AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .DFH_VALUE(DFH),
      .NUM_USER_REGS(NU), .NUM_STATUS_REGS(NS)
   ) dut (
      .pClk(pClk), .pReset_n(pReset_n),
      .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr),
      .mmio_wr_len(mmio_wr_len), .mmio_wr_data(mmio_wr_data),
      .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr),
      .mmio_rd_len(mmio_rd_len), .mmio_rd_tid(mmio_rd_tid),
      .c2_rsp_valid(c2_rsp_valid), .c2_rsp_tid(c2_rsp_tid), .c2_rsp_data(c2_rsp_data),
      .usr_regs(usr_regs), .usr_wr_pulse(usr_wr_pulse), .status_regs(status_regs)
   );

   typedef struct {
      logic [8:0]  tid;
      logic [63:0] data;
   } rspT;

   rspT         expQ[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] edgeCnt = '0;

   // Model: register contents by index, counter expressed as the edge at which it read 0
   logic [63:0] scratchM;
   logic [63:0] usrM [NU];
   logic [63:0] zeroEdge;
   int          pulseExp [NU];
   int          pulseSeen [NU];

   always @(posedge pClk) edgeCnt <= edgeCnt + 64'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Value of 8-byte register idx as seen by a read accepted at edge acc
   function automatic logic [63:0] regValue(input int idx, input logic [63:0] acc);
      if (idx == 0) return DFH;
      if (idx == 1) return ID_L;
      if (idx == 2) return ID_H;
      if (idx == 5) return scratchM;
      if (idx == 6) return acc - zeroEdge;
      if (idx >= 8 && idx < 8 + NU) return usrM[idx-8];
      if (idx >= 8 + NU && idx < 8 + NU + NS) return status_regs[64*(idx-8-NU) +: 64];
      return 64'd0;
   endfunction

   function automatic logic [63:0] modelRead(input logic [15:0] a, input logic [1:0] len,
                                             input logic [63:0] acc);
      logic [63:0] v;
      v = regValue(int'(a[15:1]), acc);
      if (len == 2'd0) return a[0] ? {v[63:32], v[63:32]} : {v[31:0], v[31:0]};
      return v;
   endfunction

   task automatic modelWrite(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d,
                             input logic [63:0] acc);
      int          idx;
      logic [63:0] oldV, newV;
      idx = int'(a[15:1]);
      if (len > 2'd1 || (len == 2'd1 && a[0])) return;
      oldV = (idx == 5) ? scratchM : (idx >= 8 && idx < 8 + NU) ? usrM[idx-8] : 64'd0;
      if (len == 2'd1)  newV = d;
      else if (a[0])    newV = {d[31:0], oldV[31:0]};
      else              newV = {oldV[63:32], d[31:0]};
      if (idx == 5) scratchM = newV;
      if (idx == 6) zeroEdge = acc + 64'd1;
      if (idx >= 8 && idx < 8 + NU) begin
         usrM[idx-8] = newV;
         pulseExp[idx-8]++;
      end
   endtask

   task automatic doCycle(input bit wv, input logic [15:0] wa, input logic [1:0] wl,
                          input logic [63:0] wd, input bit rv, input logic [15:0] ra,
                          input logic [1:0] rl, input logic [8:0] rt);
      logic [63:0] acc;
      @(negedge pClk);
      for (int j = 0; j < NS; j++) status_regs[64*j +: 64] = {$urandom, $urandom};
      mmio_wr_valid = wv; mmio_wr_addr = wa; mmio_wr_len = wl; mmio_wr_data = wd;
      mmio_rd_valid = rv; mmio_rd_addr = ra; mmio_rd_len = rl; mmio_rd_tid = rt;
      acc = edgeCnt + 64'd1;
      if (pReset_n) begin
         if (rv) expQ.push_back('{tid: rt, data: modelRead(ra, rl, acc)});
         if (wv) modelWrite(wa, wl, wd, acc);
      end
   endtask

   task automatic idle();
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b0, 16'd0, 2'd0, 9'd0);
   endtask

   task automatic setReset(input bit level);
      @(negedge pClk);
      pReset_n = level;
      mmio_wr_valid = 1'b0;
      mmio_rd_valid = 1'b0;
      if (!level) begin
         expQ.delete();
         scratchM = '0;
         for (int i = 0; i < NU; i++) usrM[i] = '0;
      end else begin
         zeroEdge = edgeCnt;
      end
   endtask

   // Monitor: every response must match the oldest outstanding prediction
   always @(negedge pClk) begin
      if (c2_rsp_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got tid=%h data=%h, expected no response",
                     c2_rsp_tid, c2_rsp_data);
         end else begin
            rspT e;
            e = expQ.pop_front();
            checks++;
            $display("rsp tid=%h data=%h", c2_rsp_tid, c2_rsp_data);
            if (c2_rsp_tid !== e.tid || c2_rsp_data !== e.data) begin
               failures++;
               $display("FAIL rsp: got tid=%h data=%h, expected tid=%h data=%h",
                        c2_rsp_tid, c2_rsp_data, e.tid, e.data);
            end
         end
      end
      for (int i = 0; i < NU; i++) if (usr_wr_pulse[i] === 1'b1) pulseSeen[i]++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] wIdx, rIdx;
      scratchM = '0;
      zeroEdge = '0;
      for (int i = 0; i < NU; i++) begin
         usrM[i] = '0; pulseExp[i] = 0; pulseSeen[i] = 0;
      end

      repeat (3) @(negedge pClk);
      setReset(1'b1);
      idle();
      check("reset_rsp_valid", 64'(c2_rsp_valid), 64'd0);
      check("reset_usr_regs2", usr_regs[128 +: 64], 64'd0);
      check("reset_pulse", 64'(usr_wr_pulse), 64'd0);

      // Header reads
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h0000, 2'd1, 9'h0A5);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h0002, 2'd1, 9'h0A6);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h0004, 2'd1, 9'h0A7);

      // Scratch: 8B write, 4B upper-dword write, then 8B and 4B reads
      doCycle(1'b1, 16'h000A, 2'd1, 64'hDEAD_BEEF_0123_4567, 1'b0, 16'd0, 2'd0, 9'd0);
      doCycle(1'b1, 16'h000B, 2'd0, 64'h0000_0000_CAFE_F00D, 1'b0, 16'd0, 2'd0, 9'd0);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000A, 2'd1, 9'h010);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000A, 2'd0, 9'h011);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000B, 2'd0, 9'h012);

      // User reg 2: pulse timing, then a 64B write that must be ignored
      doCycle(1'b1, 16'h0014, 2'd1, 64'd5, 1'b0, 16'd0, 2'd0, 9'd0);
      idle();
      check("pulse_early", 64'(usr_wr_pulse), 64'd0);
      idle();
      check("pulse_u2", 64'(usr_wr_pulse), 64'h04);
      check("usr_reg2", usr_regs[128 +: 64], 64'd5);
      idle();
      check("pulse_clear", 64'(usr_wr_pulse), 64'd0);
      doCycle(1'b1, 16'h0014, 2'd2, 64'h77, 1'b0, 16'd0, 2'd0, 9'd0);
      idle();
      idle();
      check("pulse_64b", 64'(usr_wr_pulse), 64'd0);
      check("usr_reg2_64b", usr_regs[128 +: 64], 64'd5);

      // Same-cycle write/read returns old value, next-cycle read returns new value
      doCycle(1'b1, 16'h0014, 2'd1, 64'h99, 1'b1, 16'h0014, 2'd1, 9'h020);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h0014, 2'd1, 9'h021);

      // 16 back-to-back reads alternating status reg 0 and an unmapped address
      for (int k = 0; k < 16; k++)
         doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, (k % 2 == 1) ? 16'h7FFE : 16'h0020,
                 2'd1, 9'(9'h100 + k));

      // Cycle counter: clear, read 10 cycles later
      doCycle(1'b1, 16'h000C, 2'd1, 64'hABC, 1'b0, 16'd0, 2'd0, 9'd0);
      repeat (9) idle();
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000C, 2'd1, 9'h055);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000D, 2'd0, 9'h056);

      // Wrap: hold the counter near its maximum across the sampling edge
      @(negedge pClk);
      force dut.cycleCntReg = 64'hFFFF_FFFF_FFFF_FFFE;
      mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h000C; mmio_rd_len = 2'd1; mmio_rd_tid = 9'h1F0;
      expQ.push_back('{tid: 9'h1F0, data: 64'hFFFF_FFFF_FFFF_FFFF});
      @(negedge pClk);
      force dut.cycleCntReg = 64'hFFFF_FFFF_FFFF_FFFF;
      mmio_rd_tid = 9'h1F1;
      expQ.push_back('{tid: 9'h1F1, data: 64'd0});
      @(negedge pClk);
      release dut.cycleCntReg;
      mmio_rd_valid = 1'b0;
      doCycle(1'b1, 16'h000C, 2'd0, 64'd1, 1'b0, 16'd0, 2'd0, 9'd0);
      repeat (4) idle();
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000C, 2'd1, 9'h057);

      // Randomized traffic across the whole map
      for (int n = 0; n < 400; n++) begin
         int wi, ri;
         wi = $urandom_range(0, 23);
         ri = $urandom_range(0, 23);
         wIdx = (wi == 23) ? 15'h7FFF : 15'(wi);
         rIdx = (ri == 23) ? 15'h7FFF : 15'(ri);
         doCycle($urandom_range(0, 9) < 4, {wIdx, 1'($urandom)}, 2'($urandom_range(0, 3)),
                 {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, {rIdx, 1'($urandom)}, 2'($urandom_range(0, 3)),
                 9'($urandom));
      end

      repeat (3) idle();
      for (int w = 0; w < 10 && expQ.size() > 0; w++) idle();
      check("drain_pending", 64'(expQ.size()), 64'd0);
      for (int i = 0; i < NU; i++) begin
         check($sformatf("pulse_count_%0d", i), 64'(pulseSeen[i]), 64'(pulseExp[i]));
         check($sformatf("usr_regs_%0d", i), usr_regs[64*i +: 64], usrM[i]);
      end

      // Reset with a read in flight and requests presented during reset
      repeat (3) idle();
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000A, 2'd1, 9'h111);
      setReset(1'b0);
      doCycle(1'b1, 16'h000A, 2'd1, 64'h1234, 1'b1, 16'h000A, 2'd1, 9'h1AB);
      check("rst_rsp_valid", 64'(c2_rsp_valid), 64'd0);
      check("rst_rsp_tid", 64'(c2_rsp_tid), 64'd0);
      check("rst_rsp_data", c2_rsp_data, 64'd0);
      idle();
      check("rst_usr_regs", 64'(usr_regs != '0), 64'd0);
      check("rst_pulse", 64'(usr_wr_pulse), 64'd0);
      repeat (3) idle();
      setReset(1'b1);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000A, 2'd1, 9'h0C0);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h0014, 2'd1, 9'h0C1);
      doCycle(1'b0, 16'd0, 2'd0, 64'd0, 1'b1, 16'h000C, 2'd1, 9'h0C2);

      repeat (3) idle();
      for (int w = 0; w < 10 && expQ.size() > 0; w++) idle();
      check("final_drain", 64'(expQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/ccip_mmio_csr_bank.md
Name: ccip_mmio_csr_bank

Overview:
- CSR register bank sitting directly downstream of the CCI-P clock-crossing shim, in the AFU clock domain.
- Decodes flattened CCI-P MMIO write and read requests.
- Holds the AFU DFH/ID header, a scratch register, a free-running cycle counter, RW control registers for the NIC top level, and RO status registers fed by the NIC.
- Returns MMIO read responses on a flattened C2 channel with fixed latency.

Parameters:
- AFU_ID_L, 64'h0, low 64 bits of AFU GUID (RO at byte 0x08).
- AFU_ID_H, 64'h0, high 64 bits of AFU GUID (RO at byte 0x10).
- DFH_VALUE, 64'h1000_0000_0000_0001, RO value at byte 0x00.
- NUM_USER_REGS, 8, RW control registers at byte 0x40 + 8*i (1..32).
- NUM_STATUS_REGS, 4, RO status registers at byte 0x40 + 8*NUM_USER_REGS + 8*j (1..32).

Ports:
- pClk  in  1  AFU clock; all logic rising-edge.
- pReset_n  in  1  synchronous, active-low reset.
- mmio_wr_valid  in  1  MMIO write request, one-cycle.
- mmio_wr_addr  in  16  DW (4-byte) address.
- mmio_wr_len  in  2  0=4B, 1=8B, 2=64B.
- mmio_wr_data  in  64  write data; 4B writes use [31:0].
- mmio_rd_valid  in  1  MMIO read request, one-cycle.
- mmio_rd_addr  in  16  DW address.
- mmio_rd_len  in  2  0=4B, 1=8B.
- mmio_rd_tid  in  9  transaction ID.
- c2_rsp_valid  out  1  read response valid.
- c2_rsp_tid  out  9  echoed TID.
- c2_rsp_data  out  64  response data.
- usr_regs  out  64*NUM_USER_REGS  current RW register values; reg i at [64*i +: 64].
- usr_wr_pulse  out  NUM_USER_REGS  one-cycle pulse per written register.
- status_regs  in  64*NUM_STATUS_REGS  RO status values, sampled at read.

Behaviour:
- Decode: register index = addr[15:1]; addr[0] selects dword for 4B accesses.
- Map (byte): 0x00 DFH, 0x08 ID_L, 0x10 ID_H, 0x18/0x20 reserved (read 0), 0x28 SCRATCH RW, 0x30 CYCLE_CNT, 0x38 reserved, then user regs, then status regs. Unmapped reads return 0; unmapped writes are ignored.
- Writes:
  - 8B with addr[0]=1: ignored.
  - 8B: full register update.
  - 4B: updates dword addr[0] from wr_data[31:0].
  - 64B: ignored entirely (no update, no pulse).
  - Write accepted at edge T: register and usr_regs show new value after edge T+1; usr_wr_pulse[i]=1 for exactly that cycle, coincident with the new value.
  - Writes to RO/reserved addresses: no effect.
- CYCLE_CNT: 64-bit, +1 every cycle, wraps 2^64-1 -> 0. Any write to 0x30 (4B or 8B) loads 0 on the next edge; counting resumes the following cycle.
- Reads, fixed 2-cycle pipeline, no backpressure (C2 has none):
  - Stage 1 (edge T): latch tid/addr/len, sample the selected source (counter value at T, status_regs at T).
  - Stage 2 (edge T+1): format data; c2_rsp_valid=1 for exactly the cycle after edge T+1.
  - Back-to-back reads every cycle sustained; responses stay in request order.
  - 8B read: full register. 4B read: selected dword replicated in [31:0] and [63:32]. rd_len 2/3: treated as 8B.
- Same-cycle write and read to the same register: read returns the old value. Write at T, read at T+1 returns the new value.
- Reset (pReset_n=0 at an edge): SCRATCH, usr_regs, CYCLE_CNT = 0; c2_rsp_valid=0, c2_rsp_tid=0, c2_rsp_data=0; usr_wr_pulse=0. In-flight reads are dropped and produce no response. Requests presented while reset is asserted are ignored.
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset, then 8B read at DW 0x0000, tid 0x0A5 -> two cycles later rsp_valid=1, tid=0x0A5, data=DFH_VALUE; reads at DW 0x2/0x4 return AFU_ID_L/AFU_ID_H.
- 8B write 0xDEAD_BEEF_0123_4567 to SCRATCH (DW 0x0A); 4B write 0xCAFEF00D to DW 0x0B -> 8B read returns 0xCAFE_F00D_0123_4567; 4B read DW 0x0A returns 0x01234567_01234567.
- 8B write 0x5 to user reg 2 (DW 0x14) -> usr_wr_pulse=3'b100 for one cycle, usr_regs[191:128]=5. 64B write to the same address -> no pulse, value unchanged.
- Reads on 16 consecutive cycles alternating status reg 0 / unmapped DW 0x7FFE -> 16 consecutive responses, in order, with correct TIDs; unmapped responses return 0.
- Write to CYCLE_CNT, then read 10 cycles later -> value 9 (±1 per the defined sampling edge); force the counter to 2^64-1 via a bench hook -> wraps to 0.
- Issue a read, assert pReset_n=0 on the next cycle -> no c2_rsp_valid ever; usr_regs and SCRATCH read 0 after reset.
